// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between instruction fetch (IF) and data (MEM) requests.
// Each access runs IDLE -> ISSUE -> WAIT -> DONE and finishes with a one-cycle ready pulse.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned STARVE_MAX  = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              sel_d_q, sel_d_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              busy_q, busy_d;
    logic              pick_if;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        sel_d_d     = sel_d_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        if_rdata_d  = '0;
        d_rdata_d   = '0;
        pick_if     = if_req && (!d_req || (starve_q == STV_W'(STARVE_MAX)));

        unique case (state_q)
            StIdle: begin
                if (if_req || d_req) begin
                    // mem_en is registered, so it rises together with the move into ISSUE
                    mem_en_d = 1'b1;
                    state_d  = StIssue;
                    if (pick_if) begin
                        sel_d_d    = 1'b0;
                        starve_d   = '0;
                        mem_addr_d = if_addr;
                        mem_we_d   = 1'b0;
                    end else begin
                        sel_d_d     = 1'b1;
                        mem_addr_d  = d_addr;
                        mem_we_d    = d_we;
                        mem_wdata_d = d_wdata;
                        if (if_req && (starve_q != STV_W'(STARVE_MAX))) begin
                            starve_d = starve_q + STV_W'(1);
                        end
                    end
                end
            end
            StIssue: begin
                cnt_d   = CNT_W'(MEM_LATENCY);
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StDone;
                    if (sel_d_q) begin
                        d_ready_d = 1'b1;
                        d_rdata_d = mem_we_q ? '0 : mem_rdata;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            starve_q    <= '0;
            sel_d_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            sel_d_q     <= sel_d_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LATENCY 2, 1, 5), each with a memory model
// that drives valid read data only in the cycle MEM_LATENCY after its mem_en cycle.
module tb_mem_port_arbiter;

    localparam int NI = 3;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req   [NI];
    logic        d_req    [NI];
    logic        d_we     [NI];
    logic [31:0] if_addr  [NI];
    logic [31:0] d_addr   [NI];
    logic [31:0] d_wdata  [NI];
    logic [31:0] if_rdata [NI];
    logic [31:0] d_rdata  [NI];
    logic        if_ready [NI];
    logic        d_ready  [NI];
    logic        mem_en   [NI];
    logic        mem_we   [NI];
    logic [31:0] mem_addr [NI];
    logic [31:0] mem_wdata[NI];
    logic [31:0] mem_rdata[NI];
    logic        busy     [NI];

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sbq[$];

    function automatic int lat_of(int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    endfunction

    function automatic logic [31:0] rdfn(logic [31:0] a);
        return a ^ 32'h8c49_0000;
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [7:0]  age       = 8'd0;
        logic [31:0] last_addr = 32'd0;

        mem_port_arbiter #(
            .ADDR_W     (32),
            .DATA_W     (32),
            .MEM_LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 5)),
            .STARVE_MAX (3)
        ) u_dut (
            .clk      (clk),
            .rstn     (rstn),
            .if_req   (if_req[g]),
            .if_addr  (if_addr[g]),
            .if_rdata (if_rdata[g]),
            .if_ready (if_ready[g]),
            .d_req    (d_req[g]),
            .d_we     (d_we[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_rdata  (d_rdata[g]),
            .d_ready  (d_ready[g]),
            .mem_en   (mem_en[g]),
            .mem_we   (mem_we[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]),
            .busy     (busy[g])
        );

        always @(posedge clk) begin
            if (mem_en[g] === 1'b1) begin
                age       <= 8'd1;
                last_addr <= mem_addr[g];
            end else if (age != 8'd0 && age != 8'hff) begin
                age <= age + 8'd1;
            end
        end

        // Garbage outside the valid cycle exposes a capture in the wrong cycle
        assign mem_rdata[g] = (age == 8'(lat_of(g))) ? rdfn(last_addr) :
                              (32'hbad0_0000 | 32'(age));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_done(input int g, input string tag);
        exp_t e;
        chk({tag, "_sbq_nonempty"}, 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk({tag, "_port_is_d"}, 32'(d_ready[g]), 32'(e.is_d));
            chk({tag, "_other_ready"}, e.is_d ? 32'(if_ready[g]) : 32'(d_ready[g]), 32'd0);
            chk({tag, "_rdata"}, e.is_d ? d_rdata[g] : if_rdata[g], e.data);
        end
    endtask

    // Waits for a ready pulse, checks mem strobes on the way, then drops requests.
    task automatic wait_ready(input int g, input string tag, input int exp_k, input int exp_men,
                              input logic [31:0] addr, input bit we, input logic [31:0] wd);
        int k   = 0;
        int men = 0;
        while (k < 20 && !(if_ready[g] === 1'b1 || d_ready[g] === 1'b1)) begin
            tick();
            k++;
            if (mem_en[g] === 1'b1) begin
                men++;
                chk({tag, "_mem_addr"}, mem_addr[g], addr);
                chk({tag, "_mem_we"}, 32'(mem_we[g]), 32'(we));
                if (we) chk({tag, "_mem_wdata"}, mem_wdata[g], wd);
            end
        end
        chk({tag, "_latency"}, 32'(k), 32'(exp_k));
        chk({tag, "_mem_en_count"}, 32'(men), 32'(exp_men));
        check_done(g, tag);
        if_req[g] = 1'b0;
        d_req[g]  = 1'b0;
        tick();
        chk({tag, "_busy_after"}, 32'(busy[g]), 32'd0);
        chk({tag, "_rdata_idle"}, if_rdata[g] | d_rdata[g], 32'd0);
    endtask

    task automatic access(input int g, input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input string tag);
        exp_t e;
        e.is_d = is_d;
        e.data = (is_d && we) ? 32'd0 : rdfn(addr);
        sbq.push_back(e);
        if (is_d) begin
            d_req[g]   = 1'b1;
            d_we[g]    = we;
            d_addr[g]  = addr;
            d_wdata[g] = wd;
        end else begin
            if_req[g]  = 1'b1;
            if_addr[g] = addr;
        end
        wait_ready(g, tag, lat_of(g) + 2, 1, addr, we, wd);
    endtask

    initial begin
        exp_t e;
        int   n;
        int   last_c;
        for (int i = 0; i < NI; i++) begin
            if_req[i]  = 1'b0;
            d_req[i]   = 1'b0;
            d_we[i]    = 1'b0;
            if_addr[i] = 32'd0;
            d_addr[i]  = 32'd0;
            d_wdata[i] = 32'd0;
        end

        // Reset with both requests asserted
        rstn      = 1'b0;
        if_req[0] = 1'b1;
        d_req[0]  = 1'b1;
        for (int r = 0; r < 2; r++) begin
            tick();
            chk("rst_busy", 32'(busy[0]), 32'd0);
            chk("rst_mem_en", 32'(mem_en[0]), 32'd0);
            chk("rst_ready", {30'd0, if_ready[0], d_ready[0]}, 32'd0);
            chk("rst_rdata", if_rdata[0] | d_rdata[0], 32'd0);
            chk("rst_mem_fields", mem_addr[0] | mem_wdata[0] | 32'(mem_we[0]), 32'd0);
        end
        if_req[0] = 1'b0;
        d_req[0]  = 1'b0;
        rstn      = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy[0]), 32'd0);

        // Lone fetch and lone store
        access(0, 1'b0, 1'b0, 32'h0040_0004, 32'd0, "fetch");
        access(0, 1'b1, 1'b1, 32'h1000_8000, 32'hdead_beef, "store");

        // Both held: starvation guard interleaves IF every fourth grant
        for (int i = 0; i < 8; i++) begin
            e.is_d = (i % 4) != 3;
            e.data = e.is_d ? rdfn(32'h1000_8010) : rdfn(32'h0040_0100);
            sbq.push_back(e);
        end
        if_addr[0] = 32'h0040_0100;
        d_addr[0]  = 32'h1000_8010;
        d_we[0]    = 1'b0;
        if_req[0]  = 1'b1;
        d_req[0]   = 1'b1;
        n      = 0;
        last_c = 0;
        for (int k = 0; k < 100 && n < 8; k++) begin
            tick();
            if (if_ready[0] === 1'b1 || d_ready[0] === 1'b1) begin
                check_done(0, $sformatf("both_grant%0d", n));
                if (n > 0) chk("both_gap", 32'(cyc - last_c), 32'(lat_of(0) + 3));
                last_c = cyc;
                n++;
            end
        end
        chk("both_grants", 32'(n), 32'd8);
        if_req[0] = 1'b0;
        d_req[0]  = 1'b0;
        tick();
        tick();
        chk("both_idle", 32'(busy[0]), 32'd0);

        // Reset during WAIT of a load: abandoned, then reissued from IDLE
        d_req[0]  = 1'b1;
        d_we[0]   = 1'b0;
        d_addr[0] = 32'h1000_8020;
        tick();
        chk("rstmid_issue", 32'(mem_en[0]), 32'd1);
        tick();
        rstn = 1'b0;
        tick();
        chk("rstmid_no_ready", 32'(d_ready[0]), 32'd0);
        chk("rstmid_busy", 32'(busy[0]), 32'd0);
        rstn = 1'b1;
        tick();
        chk("rstmid_no_ready2", 32'(d_ready[0]), 32'd0);
        chk("rstmid_reissue", 32'(mem_en[0]), 32'd1);
        e.is_d = 1'b1;
        e.data = rdfn(32'h1000_8020);
        sbq.push_back(e);
        wait_ready(0, "rstmid_load", lat_of(0) + 1, 0, 32'h1000_8020, 1'b0, 32'd0);

        // Latency sweep
        access(1, 1'b0, 1'b0, 32'h0040_0008, 32'd0, "lat1_fetch");
        access(1, 1'b1, 1'b0, 32'h1000_8004, 32'd0, "lat1_load");
        access(2, 1'b0, 1'b0, 32'h0040_000c, 32'd0, "lat5_fetch");
        access(2, 1'b1, 1'b0, 32'h1000_8008, 32'd0, "lat5_load");

        chk("sbq_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
